// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared pipeline-control constants: FSM state encoding, front-end priority
// levels and the helpers that select and decode them.
package pipeline_stall_ctrl_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   // Front-end priority levels, highest first.
   localparam logic [1:0] PRIO_HOLD   = 2'd0;
   localparam logic [1:0] PRIO_BRANCH = 2'd1;
   localparam logic [1:0] PRIO_HAZARD = 2'd2;
   localparam logic [1:0] PRIO_NONE   = 2'd3;

   typedef struct packed {
      logic freeze_front;
      logic flush_ifid;
      logic flush_idex;
   } front_ctrl_t;

   // Pick the winning front-end request for this cycle.
   function automatic logic [1:0] select_prio(input logic hold,
                                              input logic branch,
                                              input logic hazard);
      logic [1:0] prio;
      if (hold) begin
         prio = PRIO_HOLD;
      end else if (branch) begin
         prio = PRIO_BRANCH;
      end else if (hazard) begin
         prio = PRIO_HAZARD;
      end else begin
         prio = PRIO_NONE;
      end
      return prio;
   endfunction

   // Map a priority level onto the IF/ID and ID/EXE controls.
   function automatic front_ctrl_t decode_prio(input logic [1:0] prio);
      front_ctrl_t ctrl;
      case (prio)
         PRIO_HOLD:   ctrl = '{freeze_front: 1'b1, flush_ifid: 1'b0, flush_idex: 1'b0};
         PRIO_BRANCH: ctrl = '{freeze_front: 1'b0, flush_ifid: 1'b1, flush_idex: 1'b1};
         PRIO_HAZARD: ctrl = '{freeze_front: 1'b1, flush_ifid: 1'b0, flush_idex: 1'b1};
         default:     ctrl = '{freeze_front: 1'b0, flush_ifid: 1'b0, flush_idex: 1'b0};
      endcase
      return ctrl;
   endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Count qualifying cycles, sticking at the all-ones value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + CNT_ONE;
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer: merges hazard freeze, branch-taken and the
// data-memory wait-state FSM (with watchdog) into per-stage hold/flush controls.
module pipeline_stall_ctrl
   import pipeline_stall_ctrl_pkg::*;
#(
   parameter int MAX_WAIT = 16,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hazardFreeze,
   input  logic             branchTaken,
   input  logic             memAccess_MEM,
   input  logic             memReady,
   output logic             freezeFront,
   output logic             flushIFID,
   output logic             flushIDEX,
   output logic             holdAll,
   output logic             memStart,
   output logic             memTimeout,
   output logic [CNT_W-1:0] stallCycles,
   output logic [CNT_W-1:0] flushEvents
);

   localparam int                WAIT_W   = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT - 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

   state_t            state;
   state_t            next_state;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] next_wait_cnt;
   logic              served;
   logic              next_served;
   logic              hold;
   logic              start;
   logic              timeout;
   front_ctrl_t       front;

   // State, watchdog count and served flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= RUN;
         wait_cnt <= '0;
         served   <= 1'b0;
      end else begin
         state    <= next_state;
         wait_cnt <= next_wait_cnt;
         served   <= next_served;
      end
   end

   // Wait-state FSM: launch the SRAM access, hold until ready or watchdog expiry.
   always_comb begin
      next_state    = state;
      next_wait_cnt = wait_cnt;
      next_served   = served;
      hold          = 1'b0;
      start         = 1'b0;
      timeout       = 1'b0;
      case (state)
         RUN: begin
            if (memAccess_MEM && !served) begin
               start         = 1'b1;
               hold          = 1'b1;
               next_state    = MEM_WAIT;
               next_wait_cnt = '0;
            end else begin
               next_state = RUN;
            end
         end
         MEM_WAIT: begin
            if (memReady) begin
               next_state    = RUN;
               next_served   = 1'b1;
               next_wait_cnt = '0;
            end else if (wait_cnt == WAIT_MAX) begin
               // Abort: let the instruction retire rather than lock up.
               timeout       = 1'b1;
               next_state    = RUN;
               next_served   = 1'b1;
               next_wait_cnt = '0;
            end else begin
               hold          = 1'b1;
               next_wait_cnt = wait_cnt + WAIT_ONE;
            end
         end
         default: begin
            next_state    = RUN;
            next_wait_cnt = '0;
            next_served   = 1'b0;
         end
      endcase

      front = decode_prio(select_prio(hold, branchTaken, hazardFreeze));

      // The MEM-stage instruction has moved on once nothing holds it in place.
      if ((state == RUN) && !hold && !front.freeze_front) begin
         next_served = 1'b0;
      end else begin
         next_served = next_served;
      end
   end

   // Drive the control outputs; everything is forced low while reset is applied.
   always_comb begin
      freezeFront = 1'b0;
      flushIFID   = 1'b0;
      flushIDEX   = 1'b0;
      holdAll     = 1'b0;
      memStart    = 1'b0;
      memTimeout  = 1'b0;
      if (!rst) begin
         freezeFront = front.freeze_front;
         flushIFID   = front.flush_ifid;
         flushIDEX   = front.flush_idex;
         holdAll     = hold;
         memStart    = start;
         memTimeout  = timeout;
      end else begin
         freezeFront = 1'b0;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (freezeFront),
      .count (stallCycles)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flushIFID),
      .count (flushEvents)
   );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl (MAX_WAIT=4, CNT_W=16).
module tb_pipeline_stall_ctrl;
   import pipeline_stall_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hazardFreeze = 1'b0;
   logic        branchTaken = 1'b0;
   logic        memAccess_MEM = 1'b0;
   logic        memReady = 1'b0;
   logic        freezeFront;
   logic        flushIFID;
   logic        flushIDEX;
   logic        holdAll;
   logic        memStart;
   logic        memTimeout;
   logic [15:0] stallCycles;
   logic [15:0] flushEvents;

   int n_vec  = 0;
   int n_miss = 0;

   pipeline_stall_ctrl #(.MAX_WAIT(4), .CNT_W(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .hazardFreeze  (hazardFreeze),
      .branchTaken   (branchTaken),
      .memAccess_MEM (memAccess_MEM),
      .memReady      (memReady),
      .freezeFront   (freezeFront),
      .flushIFID     (flushIFID),
      .flushIDEX     (flushIDEX),
      .holdAll       (holdAll),
      .memStart      (memStart),
      .memTimeout    (memTimeout),
      .stallCycles   (stallCycles),
      .flushEvents   (flushEvents)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Move to just after the next rising edge, where inputs are driven.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic hz, input logic br, input logic ma, input logic mr);
      hazardFreeze  = hz;
      branchTaken   = br;
      memAccess_MEM = ma;
      memReady      = mr;
   endtask

   // Compare the six control outputs at the falling edge.
   task automatic check_ctrl(input string tag, input logic [5:0] exp);
      @(negedge clk);
      check_eq({tag, ".ctrl"},
               {26'd0, freezeFront, flushIFID, flushIDEX, holdAll, memStart, memTimeout},
               {26'd0, exp});
   endtask

   initial begin
      // ctrl bit order: freezeFront flushIFID flushIDEX holdAll memStart memTimeout
      // Reset held with every input high.
      set_in(1'b1, 1'b1, 1'b1, 1'b1);
      next_cycle();
      next_cycle();
      check_ctrl("rst_all_in", 6'b000000);
      check_eq("rst_stall", {16'd0, stallCycles}, 32'd0);
      check_eq("rst_flush", {16'd0, flushEvents}, 32'd0);

      next_cycle();
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      check_ctrl("idle", 6'b000000);

      // Hazard freeze for two cycles.
      next_cycle(); set_in(1'b1, 1'b0, 1'b0, 1'b0); check_ctrl("haz_c0", 6'b101000);
      next_cycle();                                  check_ctrl("haz_c1", 6'b101000);
      next_cycle(); set_in(1'b0, 1'b0, 1'b0, 1'b0); check_ctrl("haz_end", 6'b000000);
      check_eq("haz_stall", {16'd0, stallCycles}, 32'd2);

      // Branch overrides hazard.
      next_cycle(); set_in(1'b1, 1'b1, 1'b0, 1'b0); check_ctrl("br_haz", 6'b011000);
      next_cycle(); set_in(1'b0, 1'b0, 1'b0, 1'b0); check_ctrl("br_end", 6'b000000);
      check_eq("br_flush", {16'd0, flushEvents}, 32'd1);
      check_eq("br_stall", {16'd0, stallCycles}, 32'd2);

      // Memory access completed by memReady three cycles after the start.
      next_cycle(); set_in(1'b0, 1'b0, 1'b1, 1'b0); check_ctrl("mem_c0", 6'b100110);
      next_cycle();                                  check_ctrl("mem_c1", 6'b100100);
      next_cycle();                                  check_ctrl("mem_c2", 6'b100100);
      next_cycle(); set_in(1'b0, 1'b0, 1'b1, 1'b1); check_ctrl("mem_c3", 6'b000000);
      // Same instruction stays in MEM behind a front-end freeze: no restart.
      next_cycle(); set_in(1'b1, 1'b0, 1'b1, 1'b0); check_ctrl("mem_srv0", 6'b101000);
      check_eq("mem_stall", {16'd0, stallCycles}, 32'd5);
      next_cycle();                                  check_ctrl("mem_srv1", 6'b101000);
      next_cycle(); set_in(1'b0, 1'b0, 1'b0, 1'b0); check_ctrl("mem_end", 6'b000000);
      check_eq("mem_stall2", {16'd0, stallCycles}, 32'd7);

      // Watchdog: memReady never arrives.
      next_cycle(); set_in(1'b0, 1'b0, 1'b1, 1'b0); check_ctrl("wd_c0", 6'b100110);
      next_cycle();                                  check_ctrl("wd_c1", 6'b100100);
      next_cycle();                                  check_ctrl("wd_c2", 6'b100100);
      next_cycle();                                  check_ctrl("wd_c3", 6'b100100);
      next_cycle();                                  check_ctrl("wd_c4", 6'b000001);
      next_cycle(); set_in(1'b0, 1'b0, 1'b0, 1'b0); check_ctrl("wd_after", 6'b000000);
      check_eq("wd_stall", {16'd0, stallCycles}, 32'd11);

      // Branch arriving during MEM_WAIT waits for the hold to lift.
      next_cycle(); set_in(1'b0, 1'b1, 1'b1, 1'b0); check_ctrl("mwbr_c0", 6'b100110);
      next_cycle();                                  check_ctrl("mwbr_c1", 6'b100100);
      next_cycle(); set_in(1'b0, 1'b1, 1'b1, 1'b1); check_ctrl("mwbr_c2", 6'b011000);
      next_cycle(); set_in(1'b0, 1'b0, 1'b0, 1'b0); check_ctrl("mwbr_end", 6'b000000);
      check_eq("mwbr_flush", {16'd0, flushEvents}, 32'd2);
      check_eq("mwbr_stall", {16'd0, stallCycles}, 32'd13);

      // Reset asserted mid-MEM_WAIT drops everything at once.
      next_cycle(); set_in(1'b0, 1'b0, 1'b1, 1'b0); check_ctrl("rmw_c0", 6'b100110);
      next_cycle();                                  check_ctrl("rmw_c1", 6'b100100);
      rst = 1'b1;
      #1;
      check_eq("rmw_async", {26'd0, freezeFront, flushIFID, flushIDEX, holdAll, memStart, memTimeout}, 32'd0);
      check_eq("rmw_cnt", {16'd0, stallCycles}, 32'd0);
      next_cycle(); set_in(1'b0, 1'b0, 1'b0, 1'b0);
      next_cycle(); rst = 1'b0;                      check_ctrl("rmw_after", 6'b000000);

      // Saturation: freeze far longer than the counter range.
      next_cycle(); set_in(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 65540; i++) begin
         next_cycle();
      end
      check_ctrl("sat_ctrl", 6'b101000);
      check_eq("sat_stall", {16'd0, stallCycles}, 32'd65535);
      next_cycle(); next_cycle();
      @(negedge clk);
      check_eq("sat_hold", {16'd0, stallCycles}, 32'd65535);
      check_eq("sat_flush", {16'd0, flushEvents}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
